pipeline_front_regs: RTL

- Sequential consumer of the hazard unit's stall/flush/forward controls in the 5-stage RV32I pipeline.
- Holds the PC register, the IF/ID register and the ID/EX register, and implements the execute-stage forwarding muxes for operands A and B.
- Provides saturating stall and flush performance counters.
- Sits between fetch/decode datapath and the ALU; all hazard decisions are made upstream, this block only applies them.

---
 rtl/riscv_pipe_pkg.sv | 24 ++
 rtl/pipe_reg.sv | 25 ++
 rtl/pipeline_front_regs.sv | 112 +++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RV32I pipeline: decoded control bundle, forward selects
// and the canonical NOP.
package riscv_pipe_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: clear dominates enable, and clear reloads the
// reset value so a flush leaves the stage in its post-reset state.
module pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_front_regs.sv
// PC, IF/ID and ID/EX registers with execute-stage operand forwarding and
// saturating stall/flush counters; applies hazard-unit decisions only.
module pipeline_front_regs
    import riscv_pipe_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = riscv_pipe_pkg::NOP_INSTR,
    parameter int               CNT_W     = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [XLEN-1:0]  PCNextF,
    output logic [XLEN-1:0]  PCF,
    input  logic [31:0]      InstrF,
    input  logic [XLEN-1:0]  PCPlus4F,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    output logic [31:0]      InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  ctrl_t            CtrlD,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output ctrl_t            CtrlE,
    output logic             ValidE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  ResultW,
    output logic [XLEN-1:0]  SrcAE,
    output logic [XLEN-1:0]  WriteDataE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int DW = 32 + 2 * XLEN + 1;
    localparam int EW = 5 * XLEN + 15 + $bits(ctrl_t) + 1;
    localparam logic [DW-1:0] D_RESET = {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}, 1'b0};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                                 input logic [XLEN-1:0] rf,
                                                 input logic [XLEN-1:0] w,
                                                 input logic [XLEN-1:0] m);
        case (sel)
            FWD_W:   return w;
            FWD_M:   return m;
            default: return rf;
        endcase
    endfunction

    logic [DW-1:0] d_q;
    logic [EW-1:0] e_q;

    pipe_reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .resetn(resetn), .en(~StallF), .clr(1'b0),
        .d(PCNextF), .q(PCF)
    );

    pipe_reg #(.WIDTH(DW), .RESET_VAL(D_RESET)) u_ifid (
        .clk(clk), .resetn(resetn), .en(~StallD), .clr(FlushD),
        .d({InstrF, PCF, PCPlus4F, 1'b1}), .q(d_q)
    );

    assign {InstrD, PCD, PCPlus4D, ValidD} = d_q;

    // A flushed E slot zeroes its register indices so x0 never matches for forwarding.
    pipe_reg #(.WIDTH(EW), .RESET_VAL('0)) u_idex (
        .clk(clk), .resetn(resetn), .en(1'b1), .clr(FlushE),
        .d({RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, CtrlD, ValidD}),
        .q(e_q)
    );

    assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, CtrlE, ValidE} = e_q;

    assign SrcAE      = fwd_mux(ForwardAE, RD1E, ResultW, ALUResultM);
    assign WriteDataE = fwd_mux(ForwardBE, RD2E, ResultW, ALUResultM);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallD) StallCount <= sat_inc(StallCount);
            if (FlushE) FlushCount <= sat_inc(FlushCount);
        end
    end

    // Select 2'b11 is reserved; the mux falls back to the register file.
    a_fwd_reserved: assert property (@(posedge clk) disable iff (!resetn)
        (ForwardAE != 2'b11) && (ForwardBE != 2'b11));

endmodule
